// File: rtl/rs_syndrome_checker.sv
// Receive-side syndrome checker for the beat-parallel systematic RS encoder.
// Forwards message beats with one cycle of latency and flags codewords whose syndromes are nonzero.
module rs_syndrome_checker #(
  parameter int                 ENC_SYM  = 4,
  parameter int                 EGF_DIM  = 4,
  parameter logic [EGF_DIM:0]   EGF_POLY = 5'h13,
  parameter int                 MSG_LEN  = 8,
  parameter int                 PAR_LEN  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enc_valid,
  input  logic [ENC_SYM*EGF_DIM-1:0]   enc_data,
  output logic                         dec_valid,
  output logic [ENC_SYM*EGF_DIM-1:0]   dec_data,
  output logic                         dec_last,
  output logic                         dec_done,
  output logic                         dec_err,
  output logic [PAR_LEN*EGF_DIM-1:0]   dec_syn
);

  localparam int MSG_BEATS = MSG_LEN / ENC_SYM;
  localparam int PAR_BEATS = PAR_LEN / ENC_SYM;
  localparam int BEATS     = MSG_BEATS + PAR_BEATS;
  localparam int CNT_W     = $clog2(BEATS + 1);
  localparam int GF_ORDER  = (1 << EGF_DIM) - 1;

  if ((MSG_LEN % ENC_SYM) != 0 || (PAR_LEN % ENC_SYM) != 0 ||
      (MSG_LEN + PAR_LEN) > GF_ORDER || EGF_POLY[EGF_DIM] != 1'b1) begin : g_bad_params
    $fatal(1, "rs_syndrome_checker: illegal code parameters");
  end

  // Shift-and-reduce product; every call below has a constant operand, so each
  // collapses to a small XOR network at elaboration.
  function automatic logic [EGF_DIM-1:0] gf_mul(input logic [EGF_DIM-1:0] a,
                                                input logic [EGF_DIM-1:0] b);
    logic [EGF_DIM-1:0] acc;
    logic [EGF_DIM-1:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < EGF_DIM; i++) begin
      if (b[i]) acc ^= x;
      x = {x[EGF_DIM-2:0], 1'b0} ^ (x[EGF_DIM-1] ? EGF_POLY[EGF_DIM-1:0] : '0);
    end
    return acc;
  endfunction

  function automatic logic [EGF_DIM-1:0] gf_alpha_pow(input int e);
    logic [EGF_DIM-1:0] r;
    r = EGF_DIM'(1);
    for (int i = 0; i < (e % GF_ORDER); i++) r = gf_mul(r, EGF_DIM'(2));
    return r;
  endfunction

  typedef enum logic {ST_MSG, ST_PAR} state_t;

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [PAR_LEN*EGF_DIM-1:0]   syn_q;
  logic [PAR_LEN*EGF_DIM-1:0]   syn_next;

  // S_j advances by a whole beat: scale by alpha^(j*ENC_SYM), then add each
  // symbol weighted by its degree within the beat (MSB symbol is highest).
  always_comb begin
    // NOTE: default every bit first so no path leaves syn_next unassigned and infers a latch.
    syn_next = '0;
    for (int j = 1; j <= PAR_LEN; j++) begin
      syn_next[(PAR_LEN-j)*EGF_DIM +: EGF_DIM] =
        gf_mul(syn_q[(PAR_LEN-j)*EGF_DIM +: EGF_DIM], gf_alpha_pow(j * ENC_SYM));
      for (int k = 0; k < ENC_SYM; k++) begin
        syn_next[(PAR_LEN-j)*EGF_DIM +: EGF_DIM] ^=
          gf_mul(enc_data[(ENC_SYM-1-k)*EGF_DIM +: EGF_DIM], gf_alpha_pow(j * (ENC_SYM-1-k)));
      end
    end
  end

  // NOTE: the accumulators are reset so an aborted codeword cannot leak into the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_MSG;
      cnt       <= '0;
      syn_q     <= '0;
      dec_valid <= 1'b0;
      dec_data  <= '0;
      dec_last  <= 1'b0;
      dec_done  <= 1'b0;
      dec_err   <= 1'b0;
      dec_syn   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      dec_valid <= 1'b0;
      dec_last  <= 1'b0;
      dec_done  <= 1'b0;
      if (enc_valid) begin
        unique case (state)
          ST_MSG: begin
            dec_valid <= 1'b1;
            dec_data  <= enc_data;
            syn_q     <= syn_next;
            cnt       <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(MSG_BEATS - 1)) begin
              dec_last <= 1'b1;
              state    <= ST_PAR;
            end
          end
          ST_PAR: begin
            if (cnt == CNT_W'(BEATS - 1)) begin
              // Publish and clear together so the next codeword may follow without a bubble.
              dec_syn  <= syn_next;
              dec_err  <= |syn_next;
              dec_done <= 1'b1;
              syn_q    <= '0;
              cnt      <= '0;
              state    <= ST_MSG;
            end else begin
              syn_q <= syn_next;
              cnt   <= cnt + CNT_W'(1);
            end
          end
          default: state <= ST_MSG;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rs_syndrome_checker.sv
// Self-checking bench for rs_syndrome_checker: directed cases plus random codewords
// scored against a log/antilog polynomial-evaluation model.
module tb_rs_syndrome_checker;

  localparam int ENC_SYM   = 4;
  localparam int EGF_DIM   = 4;
  localparam int MSG_LEN   = 8;
  localparam int PAR_LEN   = 4;
  localparam int N         = MSG_LEN + PAR_LEN;
  localparam int MSG_BEATS = MSG_LEN / ENC_SYM;
  localparam int BEATS     = N / ENC_SYM;
  localparam int W         = ENC_SYM * EGF_DIM;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enc_valid;
  logic [W-1:0]       enc_data;
  logic               dec_valid;
  logic [W-1:0]       dec_data;
  logic               dec_last;
  logic               dec_done;
  logic               dec_err;
  logic [PAR_LEN*EGF_DIM-1:0] dec_syn;

  rs_syndrome_checker #(
    .ENC_SYM(ENC_SYM), .EGF_DIM(EGF_DIM), .EGF_POLY(5'h13),
    .MSG_LEN(MSG_LEN), .PAR_LEN(PAR_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enc_valid(enc_valid), .enc_data(enc_data),
    .dec_valid(dec_valid), .dec_data(dec_data), .dec_last(dec_last),
    .dec_done(dec_done), .dec_err(dec_err), .dec_syn(dec_syn)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: expected held outputs and the codeword under test (stream order).
  logic [W-1:0]               last_data;
  logic [PAR_LEN*EGF_DIM-1:0] held_syn;
  logic                       held_err;
  logic [EGF_DIM-1:0]         cw [N];
  int                         gexp [15];
  int                         glog [16];
  int                         gpoly [PAR_LEN+1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 15];
  endfunction

  // S_j = c(alpha^j), with stream position n carrying degree N-1-n.
  function automatic logic [PAR_LEN*EGF_DIM-1:0] model_syn();
    logic [PAR_LEN*EGF_DIM-1:0] s;
    int acc;
    s = '0;
    for (int j = 1; j <= PAR_LEN; j++) begin
      acc = 0;
      for (int n = 0; n < N; n++) acc ^= gmul(int'(cw[n]), gexp[(j * (N-1-n)) % 15]);
      s[(PAR_LEN-j)*EGF_DIM +: EGF_DIM] = EGF_DIM'(acc);
    end
    return s;
  endfunction

  // Systematic encoding: parity = m(x)*x^PAR_LEN mod g(x), by long division.
  function automatic void encode();
    int p [N];
    int coef;
    for (int n = 0; n < N; n++) p[N-1-n] = (n < MSG_LEN) ? int'(cw[n]) : 0;
    for (int d = N-1; d >= PAR_LEN; d--) begin
      coef = p[d];
      for (int i = 0; i <= PAR_LEN; i++) p[d-PAR_LEN+i] ^= gmul(coef, gpoly[i]);
    end
    for (int k = 0; k < PAR_LEN; k++) cw[MSG_LEN+k] = EGF_DIM'(p[PAR_LEN-1-k]);
  endfunction

  task automatic tick(input logic v, input logic [W-1:0] d);
    enc_valid = v;
    enc_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic l, input logic dn);
    check({tag, "_valid"}, 64'(dec_valid), 64'(v));
    check({tag, "_last"},  64'(dec_last),  64'(l));
    check({tag, "_done"},  64'(dec_done),  64'(dn));
    check({tag, "_data"},  64'(dec_data),  64'(last_data));
    check({tag, "_err"},   64'(dec_err),   64'(held_err));
    check({tag, "_syn"},   64'(dec_syn),   64'(held_syn));
  endtask

  task automatic clear_cw();
    for (int n = 0; n < N; n++) cw[n] = '0;
  endtask

  task automatic send_cw(input int gap);
    logic [W-1:0]               beat;
    logic [PAR_LEN*EGF_DIM-1:0] exp_syn;
    exp_syn = model_syn();
    for (int b = 0; b < BEATS; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          tick(1'b0, 'x);
          expect_out("gap", 1'b0, 1'b0, 1'b0);
        end
      end
      for (int k = 0; k < ENC_SYM; k++) beat[(ENC_SYM-1-k)*EGF_DIM +: EGF_DIM] = cw[b*ENC_SYM+k];
      tick(1'b1, beat);
      if (b < MSG_BEATS) begin
        last_data = beat;
        expect_out("msg", 1'b1, (b == MSG_BEATS-1), 1'b0);
      end else if (b < BEATS-1) begin
        expect_out("par", 1'b0, 1'b0, 1'b0);
      end else begin
        held_syn = exp_syn;
        held_err = (exp_syn != '0);
        expect_out("done", 1'b0, 1'b0, 1'b1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    v = 1;
    for (int i = 0; i < 15; i++) begin
      gexp[i] = v;
      glog[v] = i;
      v = v << 1;
      if (v & 16) v ^= 'h13;
    end
    glog[0] = 0;
    gpoly[0] = 1;
    for (int i = 1; i <= PAR_LEN; i++) gpoly[i] = 0;
    for (int j = 1; j <= PAR_LEN; j++) begin
      for (int i = PAR_LEN; i >= 1; i--) gpoly[i] = gpoly[i-1] ^ gmul(gpoly[i], gexp[j]);
      gpoly[0] = gmul(gpoly[0], gexp[j]);
    end

    last_data = '0;
    held_syn  = '0;
    held_err  = 1'b0;

    // Reset with enc_valid toggling: outputs stay at zero throughout.
    rst_n = 1'b1; enc_valid = 1'b0; enc_data = '0;
    #2 rst_n = 1'b0;
    #1 expect_out("rst_async", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(i[0], W'($urandom));
      expect_out("rst_hold", 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    tick(1'b0, 'x);
    expect_out("idle", 1'b0, 1'b0, 1'b0);

    // All-zero codeword.
    clear_cw();
    send_cw(0);
    check("zero_syn", 64'(dec_syn), 64'h0);

    // Single message error at degree 8.
    clear_cw();
    cw[3] = 4'h1;
    send_cw(0);
    check("single_syn", 64'(dec_syn), 64'h52A4);
    check("single_err", 64'(dec_err), 64'h1);

    // Parity error at degree 0.
    clear_cw();
    cw[N-1] = 4'h1;
    send_cw(1);
    check("parity_syn", 64'(dec_syn), 64'h1111);

    // Loopback of message 0x0123,0x4567, contiguous then with two idle cycles per gap.
    for (int n = 0; n < MSG_LEN; n++) cw[n] = EGF_DIM'(n);
    encode();
    send_cw(0);
    check("loop_syn", 64'(dec_syn), 64'h0);
    send_cw(2);
    check("loop_gap_syn", 64'(dec_syn), 64'h0);
    check("loop_gap_err", 64'(dec_err), 64'h0);

    // Back-to-back: erroneous then clean codeword with enc_valid held high.
    clear_cw();
    cw[3] = 4'h1;
    send_cw(0);
    check("b2b_first_syn", 64'(dec_syn), 64'h52A4);
    clear_cw();
    send_cw(0);
    check("b2b_second_syn", 64'(dec_syn), 64'h0);
    check("b2b_second_err", 64'(dec_err), 64'h0);

    // Reset mid-codeword: partial codeword discarded, fresh codeword is clean.
    tick(1'b0, 'x);
    expect_out("pre_abort", 1'b0, 1'b0, 1'b0);
    tick(1'b1, 16'h0001);
    last_data = 16'h0001;
    expect_out("abort_beat", 1'b1, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    last_data = '0;
    held_syn  = '0;
    held_err  = 1'b0;
    #1 expect_out("abort_rst", 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    tick(1'b0, 'x);
    expect_out("abort_idle", 1'b0, 1'b0, 1'b0);
    clear_cw();
    send_cw(0);
    check("abort_next_err", 64'(dec_err), 64'h0);

    // Random codewords: arbitrary words and encoded words with an optional error.
    for (int r = 0; r < 16; r++) begin
      for (int n = 0; n < N; n++) cw[n] = EGF_DIM'($urandom_range(0, 15));
      if (r[0]) begin
        encode();
        if ($urandom_range(0, 1) == 1) cw[$urandom_range(0, N-1)] ^= EGF_DIM'($urandom_range(1, 15));
      end
      send_cw(int'($urandom_range(0, 2)));
      if ($urandom_range(0, 2) == 0) begin
        tick(1'b0, 'x);
        expect_out("rand_idle", 1'b0, 1'b0, 1'b0);
      end
    end
    tick(1'b0, 'x);
    expect_out("final_idle", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
